// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the multi-lane fixed-point multiplier.
// Build option: FXP_MUL_OVERFLOW_FLAG_EN (sticky per-lane overflow flags).
package fixed_point_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_t;

  // Beat qualifiers that travel with the product through stage 1.
  typedef struct packed {
    logic        valid;
    round_mode_t round;
    logic        sat;
  } fxp_stage_ctrl_t;

  // Two's-complement range limits of a w-bit word, for w up to 63.
  function automatic logic signed [63:0] fxp_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fxp_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixed_point_mul_pipe_round_sat.sv
// Per-lane round / saturate step: 2W-bit product -> W-bit result.
// Build option: FXP_MUL_OVERFLOW_FLAG_EN exposes the overflow indication.
module fixed_point_round_sat
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3
) (
  input  logic signed [2*WIDTH-1:0] prod,
  input  round_mode_t               round_mode,
  input  logic                      sat,
  output logic        [WIDTH-1:0]   result
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
  ,
  output logic                      overflow
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [63:0] MAX64 = fxp_max(WIDTH);
  localparam logic signed [63:0] MIN64 = fxp_min(WIDTH);
  localparam logic signed [PW:0] MAX_R = MAX64[PW:0];
  localparam logic signed [PW:0] MIN_R = MIN64[PW:0];
  localparam logic signed [PW:0] HALF  = (PW + 1)'(1) << (FRAC_BITS - 1);

  if (WIDTH > 31) begin : g_bad_width
    $fatal(1, "fixed_point_round_sat: WIDTH must be <= 31");
  end

  logic signed [PW:0] ext;
  logic signed [PW:0] sum;
  logic signed [PW:0] r;
  logic               too_big;
  logic               too_small;

  // One extra bit keeps the half-up addend from overflowing the product.
  always_comb begin
    ext       = {prod[PW-1], prod};
    sum       = (round_mode == RND_HALF_UP) ? (ext + HALF) : ext;
    r         = sum >>> FRAC_BITS;
    too_big   = (r > MAX_R);
    too_small = (r < MIN_R);
    if (sat && too_big)        result = MAX_R[WIDTH-1:0];
    else if (sat && too_small) result = MIN_R[WIDTH-1:0];
    else                       result = r[WIDTH-1:0];
  end

`ifdef FXP_MUL_OVERFLOW_FLAG_EN
  assign overflow = too_big || too_small;
`endif

endmodule

// File: rtl/fixed_point_mul_pipe.sv
// Multi-lane pipelined signed fixed-point multiplier with shared valid/ready.
// Stage 1 multiplies, stage 2 rounds/saturates, later stages only delay.
// Build option: FXP_MUL_OVERFLOW_FLAG_EN adds OVERFLOW_OUT / OVERFLOW_CLR_IN.
module fixed_point_mul_pipe
  import fixed_point_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FRAC_BITS   = 3,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [LANES*WIDTH-1:0]   VALUE_A_IN,
  input  logic [LANES*WIDTH-1:0]   VALUE_B_IN,
  input  logic                     ROUND_IN,
  input  logic                     SAT_IN,
  input  logic                     VALID_IN,
  output logic                     READY_OUT,
  output logic [LANES*WIDTH-1:0]   VALUE_OUT,
  output logic                     VALID_OUT,
  input  logic                     READY_IN
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
  ,
  output logic [LANES-1:0]         OVERFLOW_OUT,
  input  logic                     OVERFLOW_CLR_IN
`endif
);

  localparam int PW = 2 * WIDTH;

  if (FRAC_BITS == 0 || FRAC_BITS >= WIDTH || LANES < 1 || PIPE_STAGES < 2) begin : g_bad_cfg
    $fatal(1, "fixed_point_mul_pipe: illegal parameter combination");
  end

  logic                   adv;
  fxp_stage_ctrl_t        s1_ctrl;
  logic [LANES*PW-1:0]    s1_prod;
  logic [LANES*PW-1:0]    prod_c;
  logic [LANES*WIDTH-1:0] rs_data;
  logic                   valid_q [2:PIPE_STAGES];
  logic [LANES*WIDTH-1:0] data_q  [2:PIPE_STAGES];

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign adv       = !VALID_OUT || READY_IN;
  assign READY_OUT = adv;
  assign VALID_OUT = valid_q[PIPE_STAGES];
  assign VALUE_OUT = data_q[PIPE_STAGES];

`ifdef FXP_MUL_OVERFLOW_FLAG_EN
  logic [LANES-1:0] rs_ovf;
  logic [LANES-1:0] ovf_q;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;

    assign a = VALUE_A_IN[i*WIDTH +: WIDTH];
    assign b = VALUE_B_IN[i*WIDTH +: WIDTH];
    // Sign-extend before multiplying so the full signed product is kept.
    assign prod_c[i*PW +: PW] = PW'(a) * PW'(b);

    fixed_point_round_sat #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
      .prod       (s1_prod[i*PW +: PW]),
      .round_mode (s1_ctrl.round),
      .sat        (s1_ctrl.sat),
      .result     (rs_data[i*WIDTH +: WIDTH])
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
      ,
      .overflow   (rs_ovf[i])
`endif
    );
  end

  // Stage 1: capture products together with this beat's mode bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_ctrl <= '0;
      s1_prod <= '0;
    end else if (adv) begin
      s1_ctrl.valid <= VALID_IN;
      s1_ctrl.round <= round_mode_t'(ROUND_IN);
      s1_ctrl.sat   <= SAT_IN;
      s1_prod       <= prod_c;
    end
  end

  // Stage 2 registers the rounded result; later stages are a plain delay line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 2; k <= PIPE_STAGES; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else if (adv) begin
      valid_q[2] <= s1_ctrl.valid;
      data_q[2]  <= rs_data;
      for (int k = 3; k <= PIPE_STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

`ifdef FXP_MUL_OVERFLOW_FLAG_EN
  // Sticky flags set as a beat leaves round/saturate; set beats a same-cycle clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~{LANES{OVERFLOW_CLR_IN}})
             | ({LANES{adv && s1_ctrl.valid}} & rs_ovf);
    end
  end

  assign OVERFLOW_OUT = ovf_q;
`endif

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Directed-vector bench for fixed_point_mul_pipe (8-bit words, 3 frac bits,
// 4 lanes, 3 stages). Build option: FXP_MUL_OVERFLOW_FLAG_EN.
module tb_fixed_point_mul_pipe;

  localparam int WIDTH = 8;
  localparam int FRAC  = 3;
  localparam int LANES = 4;
  localparam int PIPE  = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] VALUE_A_IN = '0;
  logic [31:0] VALUE_B_IN = '0;
  logic        ROUND_IN = 1'b0;
  logic        SAT_IN = 1'b0;
  logic        VALID_IN = 1'b0;
  logic        READY_OUT;
  logic [31:0] VALUE_OUT;
  logic        VALID_OUT;
  logic        READY_IN = 1'b1;
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
  logic [3:0]  OVERFLOW_OUT;
  logic        OVERFLOW_CLR_IN = 1'b0;
`endif

  fixed_point_mul_pipe #(
    .WIDTH       (WIDTH),
    .FRAC_BITS   (FRAC),
    .LANES       (LANES),
    .PIPE_STAGES (PIPE)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .VALUE_A_IN  (VALUE_A_IN),
    .VALUE_B_IN  (VALUE_B_IN),
    .ROUND_IN    (ROUND_IN),
    .SAT_IN      (SAT_IN),
    .VALID_IN    (VALID_IN),
    .READY_OUT   (READY_OUT),
    .VALUE_OUT   (VALUE_OUT),
    .VALID_OUT   (VALID_OUT),
    .READY_IN    (READY_IN)
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
    ,
    .OVERFLOW_OUT    (OVERFLOW_OUT),
    .OVERFLOW_CLR_IN (OVERFLOW_CLR_IN)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rnd;
    logic        sat;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] sb [$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          recv_cnt = 0;
  logic [31:0] cur_a, cur_b, cur_exp;
  logic        cur_round, cur_sat;
  bit          accepted, got_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued floor of p/2^FRAC (plus 0.5 when rounding).
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic rnd, input logic sat);
    logic [31:0] res;
    int pa, pb, r;
    real x;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      pa = int'($signed(a[i*8 +: 8]));
      pb = int'($signed(b[i*8 +: 8]));
      x  = real'(pa * pb) / 8.0;
      if (rnd) x = x + 0.5;
      r = int'($floor(x));
      if (sat) begin
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
      end
      res[i*8 +: 8] = r[7:0];
    end
    return res;
  endfunction

  // One clock: apply inputs just after the edge, then score both handshakes
  // that the next edge will complete.
  task automatic step(input bit vin, input bit rin);
    @(posedge CLK);
    #1;
    VALID_IN   = vin;
    READY_IN   = rin;
    VALUE_A_IN = cur_a;
    VALUE_B_IN = cur_b;
    ROUND_IN   = cur_round;
    SAT_IN     = cur_sat;
    #1;
    got_out = 0;
    if (VALID_OUT && READY_IN) begin
      got_out = 1;
      recv_cnt++;
      if (sb.size() == 0) chk("unexpected_output", VALUE_OUT, 32'hxxxxxxxx);
      else chk("out_value", VALUE_OUT, sb.pop_front());
    end
    accepted = VALID_IN && READY_OUT;
    if (accepted) sb.push_back(cur_exp);
  endtask

  task automatic new_operands(input bit alt, input int idx);
    cur_a = $urandom();
    cur_b = $urandom();
    if (alt) begin
      cur_round = idx[0];
      cur_sat   = ~idx[0];
    end else begin
      cur_round = 1'($urandom_range(0, 1));
      cur_sat   = 1'($urandom_range(0, 1));
    end
    cur_exp = model(cur_a, cur_b, cur_round, cur_sat);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() > 0 && cyc < 200) begin
      step(0, 1);
      cyc++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic stream(input int n, input bit alt);
    int sent, recv0, cyc;
    bit vin, rin;
    sent = 0; recv0 = recv_cnt; cyc = 0;
    new_operands(alt, 0);
    while ((sent < n || sb.size() > 0) && cyc < 3000) begin
      vin = (sent < n) && (alt ? 1'b1 : 1'($urandom_range(0, 1)));
      rin = alt ? 1'b1 : 1'($urandom_range(0, 1));
      step(vin, rin);
      if (accepted) begin
        sent++;
        new_operands(alt, sent);
      end
      cyc++;
    end
    chk("stream_count", 32'(recv_cnt - recv0), 32'(n));
  endtask

  initial begin
    int n, outs;
    logic [31:0] held;

    tbl[0] = '{32'h0C0C0C0C, 32'h10101010, 1'b0, 1'b1, 32'h18181818};
    tbl[1] = '{32'h7F0CFF01, 32'h7F100404, 1'b0, 1'b1, 32'h7F18FF00};
    tbl[2] = '{32'h7F0CFF01, 32'h7F100404, 1'b1, 1'b1, 32'h7F180001};
    tbl[3] = '{32'h0180807F, 32'h04807F7F, 1'b0, 1'b0, 32'h000010E0};
    tbl[4] = '{32'hFF7F8080, 32'h047F807F, 1'b0, 1'b1, 32'hFF7F7F80};
    tbl[5] = '{32'hFD0301FF, 32'h05050404, 1'b1, 1'b0, 32'hFE020100};

    cur_a = '0; cur_b = '0; cur_round = 0; cur_sat = 0; cur_exp = '0;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid_out", 32'(VALID_OUT), 32'd0);
    chk("rst_value_out", VALUE_OUT, 32'd0);
    chk("rst_ready_out", 32'(READY_OUT), 32'd1);
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
    chk("rst_overflow", 32'(OVERFLOW_OUT), 32'd0);
`endif
    RST = 1'b0;

    // Single beats from the table, each with a latency check.
    for (int v = 0; v < 6; v++) begin
      cur_a = tbl[v].a; cur_b = tbl[v].b;
      cur_round = tbl[v].rnd; cur_sat = tbl[v].sat; cur_exp = tbl[v].exp;
      step(1, 1);
      n = 0;
      do begin
        step(0, 1);
        n++;
      end while (!got_out && n < 10);
      chk("latency", 32'(n), 32'(PIPE));
    end

`ifdef FXP_MUL_OVERFLOW_FLAG_EN
    chk("overflow_sticky", 32'(OVERFLOW_OUT), 32'hF);
    @(posedge CLK); #1; OVERFLOW_CLR_IN = 1'b1;
    @(posedge CLK); #1; OVERFLOW_CLR_IN = 1'b0;
    chk("overflow_clear", 32'(OVERFLOW_OUT), 32'd0);
`endif

    // Same table back to back: modes differ beat to beat.
    for (int v = 0; v < 6; v++) begin
      cur_a = tbl[v].a; cur_b = tbl[v].b;
      cur_round = tbl[v].rnd; cur_sat = tbl[v].sat; cur_exp = tbl[v].exp;
      step(1, 1);
    end
    drain();

    // Full stream with ROUND and SAT toggling every beat.
    stream(12, 1'b1);

    // Random valid/ready at 50%.
    stream(20, 1'b0);

    // Stall: fill with READY_IN low, then hold and confirm nothing moves.
    new_operands(1'b0, 0);
    for (int c = 0; c < 6; c++) begin
      step(1, 0);
      if (accepted) new_operands(1'b0, 0);
    end
    held = VALUE_OUT;
    for (int c = 0; c < 4; c++) begin
      step(1, 0);
      chk("stall_ready_out", 32'(READY_OUT), 32'd0);
      chk("stall_valid_out", 32'(VALID_OUT), 32'd1);
      chk("stall_value_hold", VALUE_OUT, held);
    end
    drain();

    // Reset with three beats in flight.
    new_operands(1'b0, 0);
    step(1, 1); new_operands(1'b0, 0);
    step(1, 1); new_operands(1'b0, 0);
    step(1, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    VALID_IN = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(VALID_OUT), 32'd0);
    chk("midrst_value_out", VALUE_OUT, 32'd0);
`ifdef FXP_MUL_OVERFLOW_FLAG_EN
    chk("midrst_overflow", 32'(OVERFLOW_OUT), 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    outs = 0;
    for (int c = 0; c < 8; c++) begin
      step(0, 1);
      if (VALID_OUT) outs++;
    end
    chk("no_output_after_rst", 32'(outs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
